c17_bist_array: RTL
===================

// Module: c17_bist_array
// PURPOSE
// - NUM_CH parallel, registered copies of the c17 NAND netlist.
//   - Per channel: inputs N1,N2,N3,N6,N7; outputs N22,N23.
// - Built-in self-test: an LFSR pattern generator drives the cores; a MISR compacts their responses.
// - Sits between the gate-level benchmark cores and the test controller.
// - Gives clocked functional access plus an at-speed pass/fail check against a golden signature.
// PARAMETERS
// - NUM_CH    default 2         number of c17 channels (1..8)
// - LFSR_W    default 16        pattern LFSR width (>= 5)
// - LFSR_TAPS default 16'hD008  Fibonacci feedback tap mask (bit i set = tap on bit i)
// - SEED      default 16'h0001  LFSR load value at start; must be nonzero
// - SIG_W     default 16        MISR width
// - SIG_POLY  default 16'hB400  Galois MISR polynomial mask
// - PATTERNS  default 255       patterns applied per BIST run (1..2^16-1)
// - GOLDEN    default 16'h0000  expected final signature; set per configuration
// PORTS
// - clk        in   1          rising-edge clock
// - rst_n      in   1          asynchronous active-low reset
// - bist_mode  in   1          0 = cores fed from func_in; 1 = cores fed from LFSR
// - start      in   1          1-cycle pulse; starts a run when bist_mode=1 and state is IDLE or DONE
// - abort      in   1          forces IDLE from any state
// - func_in    in   5*NUM_CH   channel c: [5c+0]=N1, [5c+1]=N2, [5c+2]=N3, [5c+3]=N6, [5c+4]=N7
// - func_out   out  2*NUM_CH   registered core outputs: [2c]=N22, [2c+1]=N23
// - busy       out  1          high in RUN, DRAIN, CMP
// - done       out  1          high in DONE
// - pass       out  1          valid while done=1; 1 = signature matched GOLDEN
// - signature  out  SIG_W      current MISR contents
// BEHAVIOUR
// - Reset (async, rst_n=0):
//   - state=IDLE; lfsr=SEED; count=0.
//   - func_out, signature, busy, done, pass all 0.
// - Core logic per channel, combinational, then registered:
//   - N10=~(N1&N3); N11=~(N3&N6); N16=~(N2&N11); N19=~(N11&N7).
//   - N22=~(N10&N16); N23=~(N16&N19).
//   - func_out latency: 1 clk from core input.
// - Core input source:
//   - bist_mode=0: func_in.
//   - bist_mode=1: channel c bit i takes lfsr[(5c+i) % LFSR_W].
// - Next-state LFSR: lfsr <= {lfsr[LFSR_W-2:0], ^(lfsr & LFSR_TAPS)}.
// - MISR step:
//   - sig <= (sig>>1) ^ (sig[0] ? SIG_POLY : 0) ^ fold(func_out).
//   - fold: XOR of func_out split into SIG_W-bit chunks, zero-padded.
// - FSM:
//   - IDLE/DONE --start & bist_mode--> RUN.
//     - On entry: lfsr=SEED, sig=0, count=0, done=0, pass=0.
//     - start in any other state, or with bist_mode=0, is ignored.
//   - RUN: per cycle, lfsr steps, count++, and the MISR absorbs func_out from the previous cycle.
//     - The first RUN cycle absorbs nothing.
//     - When count reaches PATTERNS-1 -> DRAIN.
//   - DRAIN (1 cycle): MISR absorbs the last pattern's response -> CMP.
//   - CMP (1 cycle): pass <= (sig==GOLDEN) -> DONE.
//   - DONE: done=1; pass and signature hold until the next start or abort.
//   - abort or bist_mode falling while busy -> IDLE. signature holds its partial value; done=pass=0.
// - Run length: start to done = PATTERNS+2 cycles. Exactly PATTERNS responses enter the MISR.
// - If the LFSR reaches all-zero (bad SEED or taps), it stays at zero. No auto-recovery is required.
// CONFIGURATION
// - C17_FAULT_INJ_EN defined:
//   - Adds inputs inj_en (1) and inj_ch ($clog2(NUM_CH) bits, minimum 1).
//   - While inj_en=1, N16 of channel inj_ch is forced to 0 (stuck-at-0) in every mode.
// - C17_FAULT_INJ_EN undefined: neither port exists; cores are fault-free.
// TESTING
// - Reset: rst_n=0 mid-RUN -> next edge shows state IDLE, func_out=0, signature=0, busy=done=pass=0.
// - Functional: bist_mode=0, func_in channel 0 = 5'b11111 -> func_out[1:0]=2'b01 after 1 clk.
//   - func_in channel 0 = 5'b00000 -> func_out[1:0]=2'b00.
// - BIST, NUM_CH=2, PATTERNS=255: start pulse -> busy for 257 cycles, then done=1.
//   - signature equals the bench model's value; pass=1 when GOLDEN is set to that value.
// - Abort: abort asserted at RUN cycle 100 -> IDLE next cycle, done=0.
//   - A new start then gives the same signature as an uninterrupted run.
// - Ignored start: start while busy -> no restart; done asserts at the original cycle.
// - Fault (C17_FAULT_INJ_EN): inj_en=1, inj_ch=1, BIST run -> signature != GOLDEN, pass=0.
//   - func_out[3] (ch1 N23) reads 1 for every pattern.

Source files
------------

// File: rtl/c17_bist_array.sv
// ============================================================================
// c17_bist_array : NUM_CH registered c17 cores with LFSR stimulus and MISR check
// Optional stuck-at-0 fault injection on N16 enabled by macro C17_FAULT_INJ_EN.
// Revision 1.0
// ============================================================================
`default_nettype none

module c17_bist_array #(
   parameter int                NUM_CH    = 2,
   parameter int                LFSR_W    = 16,
   parameter logic [LFSR_W-1:0] LFSR_TAPS = 16'hD008,
   parameter logic [LFSR_W-1:0] SEED      = 16'h0001,
   parameter int                SIG_W     = 16,
   parameter logic [SIG_W-1:0]  SIG_POLY  = 16'hB400,
   parameter int                PATTERNS  = 255,
   parameter logic [SIG_W-1:0]  GOLDEN    = 16'h0000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  bist_mode_i,
   input  logic                  start_i,
   input  logic                  abort_i,
   input  logic [5*NUM_CH-1:0]   func_in_i,
`ifdef C17_FAULT_INJ_EN
   input  logic                  inj_en_i,
   input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] inj_ch_i,
`endif
   output logic [2*NUM_CH-1:0]   func_out_o,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  pass_o,
   output logic [SIG_W-1:0]      signature_o
);

   localparam int              C_CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int              C_OUT_W  = 2 * NUM_CH;
   localparam int              C_CHUNKS = (C_OUT_W + SIG_W - 1) / SIG_W;
   localparam logic [15:0]     C_LAST   = 16'(PATTERNS - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RUN   = 3'd1,
      S_DRAIN = 3'd2,
      S_CMP   = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t               state_q, state_d;
   logic [LFSR_W-1:0]    lfsr_q, lfsr_d;
   logic [SIG_W-1:0]     sig_q, sig_d;
   logic [15:0]          cnt_q, cnt_d;
   logic                 pass_q, pass_d;
   logic [C_OUT_W-1:0]   func_out_q;

   logic [C_OUT_W-1:0]   core_out;
   logic [LFSR_W-1:0]    lfsr_step;
   logic [SIG_W-1:0]     misr_step;
   logic [SIG_W-1:0]     fold;
   logic                 busy;

   // ---------------------------------------------------------------------
   // c17 cores; in BIST mode channel c bit i reads lfsr[(5c+i) % LFSR_W]
   // ---------------------------------------------------------------------
   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic [4:0] core_in;
      logic       n10, n11, n16, n19;

      for (genvar i = 0; i < 5; i++) begin : g_bit
         assign core_in[i] = bist_mode_i ? lfsr_q[(5*c + i) % LFSR_W]
                                         : func_in_i[5*c + i];
      end

      assign n10 = ~(core_in[0] & core_in[2]);
      assign n11 = ~(core_in[2] & core_in[3]);
`ifdef C17_FAULT_INJ_EN
      assign n16 = ~(core_in[1] & n11) & ~(inj_en_i & (inj_ch_i == C_CH_W'(c)));
`else
      assign n16 = ~(core_in[1] & n11);
`endif
      assign n19 = ~(n11 & core_in[4]);

      assign core_out[2*c]     = ~(n10 & n16);
      assign core_out[2*c + 1] = ~(n16 & n19);
   end

   // ---------------------------------------------------------------------
   // Response fold: XOR of SIG_W-wide chunks of the zero-padded outputs
   // ---------------------------------------------------------------------
   logic [C_CHUNKS*SIG_W-1:0] out_pad;
   logic [SIG_W-1:0]          fold_part [C_CHUNKS+1];

   assign out_pad      = (C_CHUNKS*SIG_W)'(func_out_q);
   assign fold_part[0] = '0;

   for (genvar k = 0; k < C_CHUNKS; k++) begin : g_fold
      assign fold_part[k+1] = fold_part[k] ^ out_pad[k*SIG_W +: SIG_W];
   end

   assign fold      = fold_part[C_CHUNKS];
   assign lfsr_step = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAPS)};
   assign misr_step = (sig_q >> 1) ^ (sig_q[0] ? SIG_POLY : '0) ^ fold;

   assign busy = (state_q == S_RUN) || (state_q == S_DRAIN) || (state_q == S_CMP);

   // ---------------------------------------------------------------------
   // Control FSM
   // ---------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      lfsr_d  = lfsr_q;
      sig_d   = sig_q;
      cnt_d   = cnt_q;
      pass_d  = pass_q;

      // Abort and a dropped bist_mode freeze the LFSR and MISR where they are.
      if (abort_i || (busy && !bist_mode_i)) begin
         state_d = S_IDLE;
         pass_d  = 1'b0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start_i && bist_mode_i) begin
                  state_d = S_RUN;
                  lfsr_d  = SEED;
                  sig_d   = '0;
                  cnt_d   = '0;
                  pass_d  = 1'b0;
               end
            end
            S_RUN: begin
               lfsr_d = lfsr_step;
               cnt_d  = cnt_q + 16'd1;
               // func_out still holds a pre-run value on the first RUN cycle.
               if (cnt_q != 16'd0) begin
                  sig_d = misr_step;
               end
               if (cnt_q == C_LAST) begin
                  state_d = S_DRAIN;
               end
            end
            S_DRAIN: begin
               sig_d   = misr_step;
               state_d = S_CMP;
            end
            S_CMP: begin
               pass_d  = (sig_q == GOLDEN);
               state_d = S_DONE;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         lfsr_q     <= SEED;
         sig_q      <= '0;
         cnt_q      <= '0;
         pass_q     <= 1'b0;
         func_out_q <= '0;
      end else begin
         state_q    <= state_d;
         lfsr_q     <= lfsr_d;
         sig_q      <= sig_d;
         cnt_q      <= cnt_d;
         pass_q     <= pass_d;
         func_out_q <= core_out;
      end
   end

   assign func_out_o  = func_out_q;
   assign busy_o      = busy;
   assign done_o      = (state_q == S_DONE);
   assign pass_o      = pass_q;
   assign signature_o = sig_q;

endmodule

`default_nettype wire
